// File: rtl/srpt_pkg.sv
// Shared types for the SRPT packet scheduler: entry and packet-request
// layouts plus the scheduler FSM state encoding.
package srpt_pkg;

  localparam int DBUFF_ID_W = 10;
  localparam int BYTES_W    = 32;
  localparam int PKT_LEN_W  = 16;

  // Queue entry {dbuff_id, remaining, granted, dbuffered}
  localparam int SRPT_DATA_SIZE = DBUFF_ID_W + 3 * BYTES_W;
  localparam int DBUFFERED_LO   = 0;
  localparam int DBUFFERED_HI   = 31;
  localparam int GRANTED_LO     = 32;
  localparam int GRANTED_HI     = 63;
  localparam int REMAINING_LO   = 64;
  localparam int REMAINING_HI   = 95;
  localparam int DBUFF_ID_LO    = 96;
  localparam int DBUFF_ID_HI    = 105;

  // Packet request {dbuff_id, remaining before send, len}
  localparam int PKT_REQ_SIZE   = DBUFF_ID_W + BYTES_W + PKT_LEN_W;
  localparam int PKT_LEN_LO     = 0;
  localparam int PKT_LEN_HI     = 15;
  localparam int PKT_REM_LO     = 16;
  localparam int PKT_REM_HI     = 47;
  localparam int PKT_ID_LO      = 48;
  localparam int PKT_ID_HI      = 57;

  typedef struct packed {
    logic [DBUFF_ID_W-1:0] dbuff_id;
    logic [BYTES_W-1:0]    remaining;
    logic [BYTES_W-1:0]    granted;
    logic [BYTES_W-1:0]    dbuffered;
  } entry_t;

  typedef struct packed {
    logic [DBUFF_ID_W-1:0] dbuff_id;
    logic [BYTES_W-1:0]    remaining;
    logic [PKT_LEN_W-1:0]  len;
  } pkt_req_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EVAL    = 2'd1,
    ST_EMIT    = 2'd2,
    ST_REQUEUE = 2'd3
  } state_e;

endpackage

// File: rtl/srpt_pkt_sched_if.sv
// Bus bundle between the SRPT scheduler and its three FIFOs plus the
// retire/statistics outputs. master = scheduler side, slave = environment.
interface srpt_pkt_sched_if #(
  parameter int CNT_W = 32
) ();
  import srpt_pkg::*;

  logic                      entry_in_empty_i;
  logic                      entry_in_read_en_o;
  logic [SRPT_DATA_SIZE-1:0] entry_in_data_i;
  logic                      pkt_req_full_i;
  logic                      pkt_req_write_en_o;
  logic [PKT_REQ_SIZE-1:0]   pkt_req_data_o;
  logic                      requeue_full_i;
  logic                      requeue_write_en_o;
  logic [SRPT_DATA_SIZE-1:0] requeue_data_o;
  logic                      done_o;
  logic [DBUFF_ID_W-1:0]     done_id_o;
  logic [CNT_W-1:0]          pkts_sent_o;
  logic [CNT_W-1:0]          blocked_o;

  modport master (
    input  entry_in_empty_i, entry_in_data_i, pkt_req_full_i, requeue_full_i,
    output entry_in_read_en_o, pkt_req_write_en_o, pkt_req_data_o,
           requeue_write_en_o, requeue_data_o, done_o, done_id_o,
           pkts_sent_o, blocked_o
  );

  modport slave (
    output entry_in_empty_i, entry_in_data_i, pkt_req_full_i, requeue_full_i,
    input  entry_in_read_en_o, pkt_req_write_en_o, pkt_req_data_o,
           requeue_write_en_o, requeue_data_o, done_o, done_id_o,
           pkts_sent_o, blocked_o
  );

endinterface

// File: rtl/srpt_pkt_len_calc.sv
// Sendable-length calculation: bytes may only go out while the post-send
// remaining stays at or above the larger of the ungranted and unbuffered
// byte counts; the result is clipped to one MTU.
module srpt_pkt_len_calc
  import srpt_pkg::*;
#(
  parameter int MTU_BYTES = 1500
) (
  input  logic [BYTES_W-1:0]   remaining_i,
  input  logic [BYTES_W-1:0]   granted_i,
  input  logic [BYTES_W-1:0]   dbuffered_i,
  output logic [PKT_LEN_W-1:0] len_o
);

  localparam logic [BYTES_W-1:0] MTU = BYTES_W'(MTU_BYTES);

  logic [BYTES_W-1:0] limit;
  logic [BYTES_W-1:0] avail;

  // limit -> avail -> MTU clip
  always_comb begin
    limit = (granted_i > dbuffered_i) ? granted_i : dbuffered_i;
    avail = (remaining_i > limit) ? (remaining_i - limit) : '0;
    len_o = (avail > MTU) ? MTU[PKT_LEN_W-1:0] : avail[PKT_LEN_W-1:0];
  end

endmodule

// File: rtl/srpt_pkt_sched.sv
// SRPT packet scheduler: pops one queue entry, emits at most one MTU-sized
// packet request for it, then requeues the updated entry or retires it.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a queue entry; pops and latches it
// ST_EVAL    | computes sendable len from the latched entry
// ST_EMIT    | pushes the packet request once the builder FIFO has room
// ST_REQUEUE | pushes the (updated) entry back once the queue has room
module srpt_pkt_sched
  import srpt_pkg::*;
#(
  parameter int MTU_BYTES = 1500,
  parameter int CNT_W     = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_ce,
  srpt_pkt_sched_if.master  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  entry_t             entry_q, entry_d;
  pkt_req_t           pkt_q, pkt_d;
  entry_t             rq_q, rq_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic [CNT_W-1:0]   blk_q, blk_d;

  logic [PKT_LEN_W-1:0] calc_len;
  logic [BYTES_W-1:0]   rem_after;
  logic                 run;
  logic                 pop;
  logic                 push_pkt;
  logic                 push_rq;

  srpt_pkt_len_calc #(.MTU_BYTES(MTU_BYTES)) u_len_calc (
    .remaining_i (entry_q.remaining),
    .granted_i   (entry_q.granted),
    .dbuffered_i (entry_q.dbuffered),
    .len_o       (calc_len)
  );

  // Strobes are decoded from state and the live empty/full inputs so a
  // strobe is never raised against a full FIFO; gated off in reset and ce=0.
  always_comb begin
    run       = ap_ce & ap_rst_n;
    pop       = run && (state_q == ST_IDLE) && !bus.entry_in_empty_i;
    push_pkt  = run && (state_q == ST_EMIT) && !bus.pkt_req_full_i;
    push_rq   = run && (state_q == ST_REQUEUE) && !bus.requeue_full_i;
    rem_after = entry_q.remaining - {{(BYTES_W-PKT_LEN_W){1'b0}}, pkt_q.len};
  end

  // Next-state and datapath updates for the scheduler FSM
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    pkt_d   = pkt_q;
    rq_d    = rq_q;
    sent_d  = sent_q;
    blk_d   = blk_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          entry_d = entry_t'(bus.entry_in_data_i);
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (calc_len != '0) begin
          pkt_d   = '{dbuff_id: entry_q.dbuff_id, remaining: entry_q.remaining, len: calc_len};
          state_d = ST_EMIT;
        end else begin
          rq_d    = entry_q;
          if (~&blk_q) blk_d = blk_q + CNT_ONE;
          state_d = ST_REQUEUE;
        end
      end
      ST_EMIT: begin
        if (push_pkt) begin
          entry_d.remaining = rem_after;
          if (~&sent_q) sent_d = sent_q + CNT_ONE;
          if (rem_after == '0) begin
            state_d = ST_IDLE;
          end else begin
            rq_d           = entry_q;
            rq_d.remaining = rem_after;
            state_d        = ST_REQUEUE;
          end
        end
      end
      ST_REQUEUE: begin
        if (push_rq) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; synchronous reset drops any held entry
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      entry_q <= '0;
      pkt_q   <= '0;
      rq_q    <= '0;
      sent_q  <= '0;
      blk_q   <= '0;
    end else if (ap_ce) begin
      state_q <= state_d;
      entry_q <= entry_d;
      pkt_q   <= pkt_d;
      rq_q    <= rq_d;
      sent_q  <= sent_d;
      blk_q   <= blk_d;
    end
  end

  assign bus.entry_in_read_en_o = pop;
  assign bus.pkt_req_write_en_o = push_pkt;
  assign bus.pkt_req_data_o     = pkt_q;
  assign bus.requeue_write_en_o = push_rq;
  assign bus.requeue_data_o     = rq_q;
  assign bus.done_o             = push_pkt && (rem_after == '0);
  assign bus.done_id_o          = entry_q.dbuff_id;
  assign bus.pkts_sent_o        = sent_q;
  assign bus.blocked_o          = blk_q;

endmodule

// File: tb/tb_srpt_pkt_sched.sv
// Directed bench for srpt_pkt_sched: a source model feeds queue entries,
// expected pushes go into scoreboard queues, a negedge monitor compares.
module tb_srpt_pkt_sched;
  import srpt_pkg::*;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  logic ap_ce    = 1'b1;

  srpt_pkt_sched_if bus ();

  srpt_pkt_sched dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ap_ce    (ap_ce),
    .bus      (bus)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [PKT_REQ_SIZE-1:0] pkt;
    bit                      done;
    int                      lat;
  } exp_pkt_t;

  exp_pkt_t                  exp_pkt[$];
  logic [SRPT_DATA_SIZE-1:0] exp_rq[$];
  logic [SRPT_DATA_SIZE-1:0] src[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int pop_cyc = 0;
  int pop_cnt = 0;
  bit pop_pending = 1'b0;

  function automatic logic [SRPT_DATA_SIZE-1:0] mk_ent(int id, int rem, int g, int d);
    logic [SRPT_DATA_SIZE-1:0] e;
    e = {10'(id), 32'(rem), 32'(g), 32'(d)};
    return e;
  endfunction

  function automatic logic [PKT_REQ_SIZE-1:0] mk_pkt(int id, int rem, int len);
    logic [PKT_REQ_SIZE-1:0] p;
    p = {10'(id), 32'(rem), 16'(len)};
    return p;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Monitor: compare every push against the scoreboard
  initial begin
    exp_pkt_t e;
    forever begin
      @(negedge ap_clk);
      if (bus.entry_in_read_en_o === 1'b1) begin
        pop_pending = 1'b1;
        pop_cnt++;
        pop_cyc = cyc;
      end
      if (bus.pkt_req_write_en_o === 1'b1) begin
        if (exp_pkt.size() == 0) begin
          check("unexpected_pkt_req", 128'(bus.pkt_req_data_o), 128'(0));
        end else begin
          e = exp_pkt.pop_front();
          check("pkt_req_data", 128'(bus.pkt_req_data_o), 128'(e.pkt));
          check("done_with_pkt", 128'(bus.done_o), 128'(e.done));
          if (e.done) check("done_id", 128'(bus.done_id_o), 128'(e.pkt[PKT_ID_HI:PKT_ID_LO]));
          check("pop_to_push_latency", 128'(cyc - pop_cyc), 128'(e.lat));
        end
      end else if (bus.done_o === 1'b1) begin
        check("done_without_pkt", 128'(bus.done_o), 128'(0));
      end
      if (bus.requeue_write_en_o === 1'b1) begin
        if (exp_rq.size() == 0)
          check("unexpected_requeue", 128'(bus.requeue_data_o), 128'(0));
        else
          check("requeue_data", 128'(bus.requeue_data_o), 128'(exp_rq.pop_front()));
      end
    end
  end

  // Source FIFO model (first-word-fall-through)
  initial begin
    bus.entry_in_empty_i = 1'b1;
    bus.entry_in_data_i  = '0;
    forever begin
      @(posedge ap_clk);
      #1;
      if (pop_pending) begin
        if (src.size() > 0) void'(src.pop_front());
        pop_pending = 1'b0;
      end
      bus.entry_in_empty_i = (src.size() == 0);
      bus.entry_in_data_i  = (src.size() > 0) ? src[0] : '0;
    end
  end

  task automatic send(int id, int rem, int g, int d);
    src.push_back(mk_ent(id, rem, g, d));
  endtask

  task automatic exp_p(int id, int rem, int len, bit done, int lat);
    exp_pkt_t e;
    e.pkt  = mk_pkt(id, rem, len);
    e.done = done;
    e.lat  = lat;
    exp_pkt.push_back(e);
  endtask

  task automatic wait_drain(string name);
    int t;
    t = 0;
    while ((src.size() != 0 || exp_pkt.size() != 0 || exp_rq.size() != 0) && t < 200) begin
      @(posedge ap_clk);
      t++;
    end
    if (t >= 200) timeout(name);
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  task automatic check_cnt(string name, int sent, int blk);
    check({name, "_pkts_sent"}, 128'(bus.pkts_sent_o), 128'(sent));
    check({name, "_blocked"}, 128'(bus.blocked_o), 128'(blk));
  endtask

  initial begin
    int t;
    int p0;
    bus.pkt_req_full_i = 1'b0;
    bus.requeue_full_i = 1'b0;

    // Reset with an entry already waiting: nothing may be popped
    send(1, 10000, 5000, 5000);
    exp_p(1, 10000, 1500, 1'b0, 2);
    exp_rq.push_back(mk_ent(1, 8500, 5000, 5000));
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check_cnt("reset", 0, 0);
    check("reset_read_en", 128'(bus.entry_in_read_en_o), 128'(0));
    check("reset_pkt_data", 128'(bus.pkt_req_data_o), 128'(0));
    check("reset_rq_data", 128'(bus.requeue_data_o), 128'(0));
    check("reset_done", 128'(bus.done_o), 128'(0));
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;

    // Partial MTU send, requeued
    wait_drain("t1");
    check_cnt("t1", 1, 0);

    // Final packet retires the entry
    send(3, 1000, 0, 0);
    exp_p(3, 1000, 1000, 1'b1, 2);
    wait_drain("t2");
    check_cnt("t2", 2, 0);

    // Grant-limited: nothing sendable
    send(2, 4000, 4000, 0);
    exp_rq.push_back(mk_ent(2, 4000, 4000, 0));
    wait_drain("t3");
    check_cnt("t3", 2, 1);

    // Sub-MTU send up to the grant limit, next pass blocked
    send(4, 6000, 5200, 100);
    exp_p(4, 6000, 800, 1'b0, 2);
    exp_rq.push_back(mk_ent(4, 5200, 5200, 100));
    wait_drain("t4a");
    send(4, 5200, 5200, 100);
    exp_rq.push_back(mk_ent(4, 5200, 5200, 100));
    wait_drain("t4b");
    check_cnt("t4", 3, 2);

    // Builder FIFO full for 5 EMIT cycles; a second entry waits meanwhile
    @(posedge ap_clk); #1;
    bus.pkt_req_full_i = 1'b1;
    send(5, 3000, 0, 0);
    exp_p(5, 3000, 1500, 1'b0, 7);
    exp_rq.push_back(mk_ent(5, 1500, 0, 0));
    p0 = pop_cnt;
    t = 0;
    while (pop_cnt == p0 && t < 50) begin
      @(posedge ap_clk);
      t++;
    end
    if (t >= 50) timeout("t5_pop");
    #1;
    send(6, 500, 0, 0);
    exp_p(6, 500, 500, 1'b1, 2);
    @(negedge ap_clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      check("hold_write_en", 128'(bus.pkt_req_write_en_o), 128'(0));
      check("hold_data", 128'(bus.pkt_req_data_o), 128'(mk_pkt(5, 3000, 1500)));
      check("hold_no_pop", 128'(bus.entry_in_read_en_o), 128'(0));
    end
    @(posedge ap_clk); #1;
    bus.pkt_req_full_i = 1'b0;
    wait_drain("t5");
    check_cnt("t5", 5, 2);

    // Reset while stuck in REQUEUE: held entry discarded
    @(posedge ap_clk); #1;
    bus.requeue_full_i = 1'b1;
    send(7, 9000, 0, 0);
    exp_p(7, 9000, 1500, 1'b0, 2);
    wait_drain("t6_emit");
    check("t6_rq_held_we", 128'(bus.requeue_write_en_o), 128'(0));
    check("t6_rq_held_data", 128'(bus.requeue_data_o), 128'(mk_ent(7, 7500, 0, 0)));
    check_cnt("t6_pre", 6, 2);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check_cnt("t6_rst", 0, 0);
    check("t6_rst_rq_we", 128'(bus.requeue_write_en_o), 128'(0));
    check("t6_rst_rq_data", 128'(bus.requeue_data_o), 128'(0));
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    bus.requeue_full_i = 1'b0;
    repeat (10) @(posedge ap_clk);
    @(negedge ap_clk);
    check_cnt("t6_post", 0, 0);
    check("t6_post_rq_data", 128'(bus.requeue_data_o), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
